// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared widths and constants for the
// register file and its scoreboard.
package reg_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int R0_ADDR    = 0;

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending bits, busy flags
// with writeback bypass, and a running pending count.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NUM_RD  = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CW    = ADDR_W + 1;

    logic [DEPTH-1:0] pending;
    logic             iss_ok;
    logic             set_new;
    logic             clr_old;

    assign iss_ok  = iss_en &&
                     !(ZERO_R0 != 0 && iss_addr == ADDR_W'(R0_ADDR));
    assign set_new = iss_ok && !pending[iss_addr];
    assign clr_old = wr_en && pending[wr_addr] &&
                     !(iss_ok && iss_addr == wr_addr);

    // Writeback clears, issue sets afterwards so a same-address issue wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            if (wr_en)
                pending[wr_addr] <= 1'b0;
            if (iss_ok)
                pending[iss_addr] <= 1'b1;
            pend_cnt <= pend_cnt + CW'(set_new) - CW'(clr_old);
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_busy
        logic [ADDR_W-1:0] a;
        assign a = rd_addr[k*ADDR_W +: ADDR_W];
        assign rd_busy[k] = pending[a] && !(wr_en && wr_addr == a);
    end

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port register file with writeback
// bypass and an issue/writeback scoreboard.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NUM_RD  = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_ok;

    assign wr_ok = wr_en &&
                   !(ZERO_R0 != 0 && wr_addr == ADDR_W'(R0_ADDR));

    // Data array: cleared on reset, r0 writes dropped when hardwired.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              is_r0;
        assign a     = rd_addr[k*ADDR_W +: ADDR_W];
        assign is_r0 = ZERO_R0 != 0 && a == ADDR_W'(R0_ADDR);
        assign rd_data[k*DATA_W +: DATA_W] =
            is_r0                   ? '0      :
            (wr_en && wr_addr == a) ? wr_data :
                                      regs[a];
    end

    reg_scoreboard #(
        .ADDR_W  (ADDR_W),
        .NUM_RD  (NUM_RD),
        .ZERO_R0 (ZERO_R0)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .pend_cnt (pend_cnt)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed table, corner sequences and
// randomized traffic against an array-based reference.
module tb_reg_file_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NREG = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]  rd_busy;
    logic           wr_en = 1'b0;
    logic [AW-1:0]  wr_addr = '0;
    logic [DW-1:0]  wr_data = '0;
    logic           iss_en = 1'b0;
    logic [AW-1:0]  iss_addr = '0;
    logic [AW:0]    pend_cnt;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mregs [NREG];
    bit            mpend [NREG];

    always #5 clk = ~clk;

    reg_file_sb #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .NUM_RD  (NR),
        .ZERO_R0 (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .pend_cnt (pend_cnt)
    );

    typedef struct {
        logic          rst;
        logic          wen;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          ien;
        logic [AW-1:0] iaddr;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic          b0;
        logic          b1;
        logic [AW:0]   cnt;
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t mk(
        input logic w, input int wa, input logic [DW-1:0] wd,
        input logic i, input int ia, input int a0, input int a1,
        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
        input logic b0, input logic b1, input int c);
        vec_t v;
        v.rst = 1'b0; v.wen = w; v.waddr = AW'(wa); v.wdata = wd;
        v.ien = i; v.iaddr = AW'(ia);
        v.ra0 = AW'(a0); v.ra1 = AW'(a1);
        v.d0 = d0; v.d1 = d1; v.b0 = b0; v.b1 = b1;
        v.cnt = (AW+1)'(c);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_cnt();
        int n = 0;
        foreach (mpend[i]) if (mpend[i]) n++;
        return n;
    endfunction

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (wr_en && wr_addr == a) return wr_data;
        return mregs[a];
    endfunction

    function automatic logic model_busy(input logic [AW-1:0] a);
        return mpend[a] && !(wr_en && wr_addr == a);
    endfunction

    task automatic model_edge();
        if (rst) begin
            foreach (mregs[i]) begin
                mregs[i] = '0;
                mpend[i] = 1'b0;
            end
        end else begin
            if (wr_en && wr_addr != 0) mregs[wr_addr] = wr_data;
            if (wr_en) mpend[wr_addr] = 1'b0;
            if (iss_en && iss_addr != 0) mpend[iss_addr] = 1'b1;
        end
    endtask

    task automatic drive(input logic r, input logic w, input int wa,
                         input logic [DW-1:0] wd, input logic i,
                         input int ia, input int a0, input int a1);
        @(negedge clk);
        rst      = r;
        wr_en    = w;
        wr_addr  = AW'(wa);
        wr_data  = wd;
        iss_en   = i;
        iss_addr = AW'(ia);
        rd_addr  = {AW'(a1), AW'(a0)};
        #1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_edge();
    endtask

    task automatic chk_model(input string tag);
        logic [AW-1:0] a0, a1;
        a0 = rd_addr[0 +: AW];
        a1 = rd_addr[AW +: AW];
        chk({tag, " d0"}, 64'(rd_data[0 +: DW]), 64'(model_rd(a0)));
        chk({tag, " d1"}, 64'(rd_data[DW +: DW]), 64'(model_rd(a1)));
        chk({tag, " busy"}, 64'(rd_busy),
            64'({model_busy(a1), model_busy(a0)}));
        chk({tag, " cnt"}, 64'(pend_cnt), 64'(model_cnt()));
    endtask

    initial begin
        foreach (mregs[i]) begin
            mregs[i] = 'x;
            mpend[i] = 1'b0;
        end

        tbl[0]  = mk(0, 0, 0, 0, 0, 5, 5, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 5, 5,
                     32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 5, 5,
                     32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
        tbl[3]  = mk(1, 7, 32'h12345678, 0, 0, 7, 5,
                     32'h12345678, 32'hDEADBEEF, 0, 0, 0);
        tbl[4]  = mk(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 7, 0, 32'h12345678, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 1, 3, 3, 3, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 3, 4, 0, 0, 1, 0, 1);
        tbl[8]  = mk(1, 3, 32'hAAAA0003, 0, 0, 3, 3,
                     32'hAAAA0003, 32'hAAAA0003, 0, 0, 1);
        tbl[9]  = mk(0, 0, 0, 0, 0, 3, 3,
                     32'hAAAA0003, 32'hAAAA0003, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 1, 4, 4, 4, 0, 0, 0, 0, 0);
        tbl[11] = mk(1, 4, 32'h44, 1, 4, 4, 3,
                     32'h44, 32'hAAAA0003, 0, 0, 1);
        tbl[12] = mk(0, 0, 0, 0, 0, 4, 4, 32'h44, 32'h44, 1, 1, 1);
        tbl[13] = mk(1, 4, 32'h55, 1, 9, 9, 4, 0, 32'h55, 0, 0, 1);
        tbl[14] = mk(0, 0, 0, 0, 0, 9, 4, 0, 32'h55, 1, 0, 1);
        tbl[15] = mk(1, 9, 32'h99, 0, 0, 9, 9, 32'h99, 32'h99, 0, 0, 1);
        tbl[16] = mk(0, 0, 0, 0, 0, 9, 4, 32'h99, 32'h55, 0, 0, 0);
        tbl[17] = mk(0, 0, 0, 1, 5, 5, 5,
                     32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
        tbl[18] = mk(0, 0, 0, 1, 5, 5, 2, 32'hDEADBEEF, 0, 1, 0, 1);
        tbl[19] = mk(0, 0, 0, 0, 0, 5, 5,
                     32'hDEADBEEF, 32'hDEADBEEF, 1, 1, 1);
        tbl[20] = mk(1, 5, 32'h5, 0, 0, 5, 5, 32'h5, 32'h5, 0, 0, 1);
        tbl[21] = mk(0, 0, 0, 0, 0, 5, 5, 32'h5, 32'h5, 0, 0, 0);

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        edge_step();

        foreach (tbl[n]) begin
            string tag;
            tag = $sformatf("row%0d", n);
            drive(tbl[n].rst, tbl[n].wen, int'(tbl[n].waddr),
                  tbl[n].wdata, tbl[n].ien, int'(tbl[n].iaddr),
                  int'(tbl[n].ra0), int'(tbl[n].ra1));
            chk({tag, " d0"}, 64'(rd_data[0 +: DW]), 64'(tbl[n].d0));
            chk({tag, " d1"}, 64'(rd_data[DW +: DW]), 64'(tbl[n].d1));
            chk({tag, " busy"}, 64'(rd_busy),
                64'({tbl[n].b1, tbl[n].b0}));
            chk({tag, " cnt"}, 64'(pend_cnt), 64'(tbl[n].cnt));
            edge_step();
        end

        for (int r = 1; r < NREG; r++) begin
            drive(0, 1, r, DW'(r * 32'h01010101), 0, 0, 0, 0);
            edge_step();
        end
        for (int r = 1; r < NREG; r++) begin
            drive(0, 0, 0, 0, 1, r, r, 0);
            edge_step();
        end
        drive(0, 0, 0, 0, 1, 17, 17, 31);
        chk("full cnt", 64'(pend_cnt), 64'd31);
        chk("full busy", 64'(rd_busy), 64'b11);
        edge_step();
        drive(0, 0, 0, 0, 0, 0, 1, 2);
        chk("idem cnt", 64'(pend_cnt), 64'd31);
        edge_step();

        drive(1, 1, 10, 32'hCAFEF00D, 1, 2, 10, 2);
        edge_step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst cnt", 64'(pend_cnt), 64'd0);
        for (int r = 0; r < NREG / 2; r++) begin
            drive(0, 0, 0, 0, 0, 0, r, r + NREG / 2);
            chk($sformatf("rst d%0d", r),
                64'(rd_data[0 +: DW]), 64'd0);
            chk($sformatf("rst d%0d", r + NREG / 2),
                64'(rd_data[DW +: DW]), 64'd0);
            chk($sformatf("rst busy%0d", r), 64'(rd_busy), 64'd0);
            edge_step();
        end

        for (int c = 0; c < 3000; c++) begin
            int wa, ia, a0, a1;
            logic r, w, i;
            r  = ($urandom_range(63) == 0);
            w  = $urandom_range(1);
            i  = $urandom_range(1);
            wa = $urandom_range(1) ? $urandom_range(7) : $urandom_range(31);
            ia = $urandom_range(1) ? $urandom_range(7) : $urandom_range(31);
            a0 = $urandom_range(1) ? $urandom_range(7) : $urandom_range(31);
            a1 = $urandom_range(1) ? wa : $urandom_range(31);
            drive(r, w, wa, $urandom, i, ia, a0, a1);
            chk_model($sformatf("rnd%0d", c));
            edge_step();
        end

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk_model("final");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter ZERO_R0, default 1; 1 = register 0 hardwired to zero and never pending.
REQ-005 SHALL have one clock and a synchronous active-high reset: clk  in  1  sole clock, all state updates on rising edge.
REQ-006 SHALL have rst  in  1  synchronous active-high reset.
REQ-007 SHALL have rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-008 SHALL have rd_data  out  NUM_RD*DATA_W  read data per port, same packing.
REQ-009 SHALL have rd_busy  out  NUM_RD  port k source register pending after bypass.
REQ-010 SHALL have wr_en  in  1  writeback strobe.
REQ-011 SHALL have wr_addr  in  ADDR_W  writeback address.
REQ-012 SHALL have wr_data  in  DATA_W  writeback data.
REQ-013 SHALL have iss_en  in  1  issue strobe; marks iss_addr pending.
REQ-014 SHALL have iss_addr  in  ADDR_W  destination of the issuing instruction.
REQ-015 SHALL have pend_cnt  out  ADDR_W+1  number of registers currently pending.

Function
REQ-016 SHALL write wr_data to registers[wr_addr] on the rising clk edge when wr_en=1 and rst=0; no negedge logic.
REQ-017 SHALL drop writes to address 0 when ZERO_R0=1.
REQ-018 SHALL drive rd_data combinationally from rd_addr, zero read latency.
REQ-019 SHALL bypass per port: wr_en=1 and wr_addr==rd_addr[k] (and not the r0 case) -> rd_data[k]=wr_data in the same cycle.
REQ-020 SHALL return 0 on any port reading address 0 when ZERO_R0=1, regardless of bypass.
REQ-021 SHALL hold a pending bit per register: set on iss_en at iss_addr, cleared on wr_en at wr_addr, both at clock edge.
REQ-022 SHALL, when iss_en and wr_en target the same address in one cycle, leave the bit set (new issue wins over old writeback).
REQ-023 SHALL ignore iss_en to address 0 when ZERO_R0=1.
REQ-024 SHALL drive rd_busy[k] = pending[rd_addr[k]] AND NOT (wr_en AND wr_addr==rd_addr[k]), combinational.
REQ-025 SHALL treat wr_en to a non-pending register as a plain write; pending state unchanged, no error.
REQ-026 SHALL treat iss_en to an already-pending register as idempotent; pend_cnt unchanged.
REQ-027 SHALL maintain pend_cnt as a registered counter: +1 on a 0->1 bit transition, -1 on a 1->0 transition, net 0 when both occur on different addresses; equals popcount of pending bits at every edge.
REQ-028 SHALL never let pend_cnt exceed 2**ADDR_W or go below 0.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, clear all registers to 0, all pending bits to 0 and pend_cnt to 0.
REQ-030 SHALL give rst priority over wr_en and iss_en in the same cycle; both are discarded.
REQ-031 SHALL, after reset, present rd_data=0 and rd_busy=0 for every address when wr_en=0.

Structure
REQ-032 SHALL take DATA_W/ADDR_W defaults and the r0 address constant from shared package reg_file_pkg.
REQ-033 SHALL place pending bits and pend_cnt in one sub-module, reg_scoreboard; data array, bypass and read muxes stay in the top.

Verification
REQ-034 SHALL check: reset, write r5=0xDEADBEEF, next cycle read r5 on ports 0,1 -> both 0xDEADBEEF.
REQ-035 SHALL check: wr_en r7=0x12345678 while port 0 reads r7 same cycle -> rd_data[0]=0x12345678 before the edge.
REQ-036 SHALL check: write r0=0xFFFFFFFF, iss_en r0 -> rd_data=0, rd_busy=0, pend_cnt=0.
REQ-037 SHALL check: iss r3, next cycle read r3 -> rd_busy=1, pend_cnt=1; wr r3 -> rd_busy=0 that cycle, pend_cnt=0 after edge.
REQ-038 SHALL check: iss r4 and wr r4 same cycle with r4 pending -> r4 still pending, pend_cnt=1; iss r9 + wr r4 -> pend_cnt=1.
REQ-039 SHALL check: pending r1..r31 (pend_cnt=31), then rst with wr_en=1 -> all data 0, pend_cnt=0.
